// File: rtl/gray_frame_serializer_if.sv
// Word-input handshake for gray_frame_serializer: the producer drives data/valid, the serializer returns ready.
interface gray_frame_serializer_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/gray_frame_serializer.sv
// Buffers Gray words in a small FIFO and streams them MSB-first in fixed WIDTH-cycle frames, idle frames when empty.
// Build option GRAY_ENCODE_EN: accept binary words and Gray-encode them on the way into the FIFO.
module gray_frame_serializer #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    gray_frame_serializer_if.slave     bus,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic                       frame_start,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic {
        IDLE_FRM = 1'b0,
        DATA_FRM = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] encode_word(input logic [WIDTH-1:0] w);
`ifdef GRAY_ENCODE_EN
        return w ^ (w >> 1);
`else
        return w;
`endif
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    level;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]    slot;
    logic             first;
    state_t           state;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             boundary;

    // Extra pointer bit separates full from empty when the low bits match.
    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == PW'(DEPTH));
    assign empty      = (level == '0);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign fifo_level = LW'(level);
    assign bus.in_ready = !full;

    // The first edge after reset opens slot 0 without waiting for a wrap.
    assign boundary = first || (slot == SW'(WIDTH - 1));
    assign push     = bus.in_valid && !full;
    assign pop      = boundary && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= encode_word(bus.in_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // ser_out already carries the MSB, so shreg keeps only the bits still to go.
    always_ff @(posedge clk) begin
        if (pop) shreg <= head << 1;
        else     shreg <= shreg << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE_FRM;
            slot        <= '0;
            first       <= 1'b1;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            first       <= 1'b0;
            frame_start <= boundary;
            if (boundary) begin
                slot <= '0;
                if (!empty) begin
                    state     <= DATA_FRM;
                    ser_valid <= 1'b1;
                    ser_out   <= head[WIDTH-1];
                end else begin
                    state     <= IDLE_FRM;
                    ser_valid <= 1'b0;
                    ser_out   <= 1'b0;
                end
            end else begin
                slot    <= slot + SW'(1);
                ser_out <= (state == DATA_FRM) ? shreg[WIDTH-1] : 1'b0;
            end
        end
    end
endmodule
